// File: rtl/sa_icache.sv
`default_nettype none
// ============================================================================
// Module   : sa_icache
// Brief    : Set-associative read-only instruction cache with invalid-first /
//            tree-PLRU replacement, multi-beat refill and one-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
module sa_icache #(
    parameter int NUM_SETS    = 4,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [31:0] rd,
    output logic        hit,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int c_WORD_BITS = $clog2(BLOCK_WORDS);
    localparam int c_OFF       = c_WORD_BITS + 2;
    localparam int c_IDX_BITS  = $clog2(NUM_SETS);
    localparam int c_TAG_BITS  = 32 - c_OFF - c_IDX_BITS;
    localparam int c_WAY_BITS  = $clog2(NUM_WAYS);
    localparam logic [31:0]            c_NOP       = 32'h0000_0013;
    localparam logic [c_WORD_BITS-1:0] c_LAST_WORD = c_WORD_BITS'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t r_state, w_next;

    // PLRU tree is heap-ordered from bit 1 (root); bit 0 is never used
    logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]   r_plru  [NUM_SETS];
    logic [c_TAG_BITS-1:0] r_tag   [NUM_SETS][NUM_WAYS];
    logic [31:0]           r_data  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    logic [c_WAY_BITS-1:0]  r_victim;
    logic [c_IDX_BITS-1:0]  r_idx;
    logic [c_TAG_BITS-1:0]  r_ltag;
    logic [c_WORD_BITS-1:0] r_cnt;
    logic                   r_flush_pend;

    logic [c_IDX_BITS-1:0]  w_idx;
    logic [c_TAG_BITS-1:0]  w_tag;
    logic [c_WORD_BITS-1:0] w_word;
    logic                   w_match;
    logic [c_WAY_BITS-1:0]  w_hit_way;
    logic [c_WAY_BITS-1:0]  w_victim;
    logic                   w_start;
    logic                   w_last;
    logic                   w_unused;

    assign w_word   = pc[2 +: c_WORD_BITS];
    assign w_idx    = pc[c_OFF +: c_IDX_BITS];
    assign w_tag    = pc[31 -: c_TAG_BITS];
    assign w_unused = &{1'b0, pc[1:0]};
    assign mem_addr = {r_ltag, r_idx, {c_OFF{1'b0}}};

    // Walk from the root; the final node number is {1'b1, way}
    function automatic logic [c_WAY_BITS-1:0] plru_pick(input logic [NUM_WAYS-1:0] bits);
        logic [c_WAY_BITS:0] node;
        node = (c_WAY_BITS + 1)'(1);
        for (int l = 0; l < c_WAY_BITS; l++) begin
            node = {node[c_WAY_BITS-1:0], bits[node[c_WAY_BITS-1:0]]};
        end
        return node[c_WAY_BITS-1:0];
    endfunction

    // Point every node on the path to this way at the opposite subtree
    function automatic logic [NUM_WAYS-1:0] plru_touch(input logic [NUM_WAYS-1:0] bits,
                                                       input logic [c_WAY_BITS-1:0] way);
        logic [c_WAY_BITS:0] path, node, child;
        logic [NUM_WAYS-1:0] res;
        res  = bits;
        path = {1'b1, way};
        for (int l = c_WAY_BITS; l >= 1; l--) begin
            node  = path >> l;
            child = path >> (l - 1);
            res[node[c_WAY_BITS-1:0]] = ~child[0];
        end
        return res;
    endfunction

    always_comb begin
        w_match   = 1'b0;
        w_hit_way = '0;
        w_victim  = plru_pick(r_plru[w_idx]);
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_match   = 1'b1;
                w_hit_way = c_WAY_BITS'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim = c_WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        hit     = 1'b0;
        rd      = c_NOP;
        stall   = 1'b0;
        mem_req = 1'b0;
        w_start = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                hit = pc_valid & w_match;
                if (hit) begin
                    rd = r_data[w_idx][w_hit_way][w_word];
                end
                if (flush) begin
                    stall  = 1'b1;
                    w_next = S_FLUSH;
                end else if (pc_valid && !w_match) begin
                    stall   = 1'b1;
                    w_start = 1'b1;
                    w_next  = S_REFILL;
                end
            end
            S_REFILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_rvalid && (r_cnt == c_LAST_WORD)) begin
                    w_last = 1'b1;
                    w_next = (flush || r_flush_pend) ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                stall  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_victim     <= '0;
            r_idx        <= '0;
            r_ltag       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_victim <= w_victim;
                        r_idx    <= w_idx;
                        r_ltag   <= w_tag;
                        r_cnt    <= '0;
                    end else if (hit) begin
                        r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_valid[r_idx][r_victim] <= 1'b1;
                        r_plru[r_idx]            <= plru_touch(r_plru[r_idx], r_victim);
                    end
                end
                S_FLUSH: begin
                    r_flush_pend <= 1'b0;
                    for (int s = 0; s < NUM_SETS; s++) begin
                        r_valid[s] <= '0;
                        r_plru[s]  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage needs no reset; valid bits gate every read
    always_ff @(posedge CLK) begin
        if ((r_state == S_REFILL) && mem_rvalid) begin
            r_data[r_idx][r_victim][r_cnt] <= mem_rdata;
        end
        if (w_last) begin
            r_tag[r_idx][r_victim] <= r_ltag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_icache
// Brief    : Scoreboard bench for sa_icache (default 4 sets / 4 ways / 4 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_icache;
    localparam int          c_BW  = 4;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rd;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 CLK = ~CLK;

    sa_icache #(
        .NUM_SETS   (4),
        .NUM_WAYS   (4),
        .BLOCK_WORDS(c_BW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .rd        (rd),
        .hit       (hit),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    // Backing memory: 0x100..0x10C hold 0xA0..0xA3, every word distinct
    function automatic logic [31:0] bmem(input logic [31:0] a);
        return 32'h0000_00A0 + (a >> 2) - 32'h0000_0040;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic exp_hit,
                         input logic [31:0] exp_rd, input logic exp_stall);
        step();
        pc         = addr;
        pc_valid   = 1'b1;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        sb_push($sformatf("hit@%h", addr), 32'(exp_hit));
        sb_push($sformatf("rd@%h", addr), exp_rd);
        sb_push($sformatf("stall@%h", addr), 32'(exp_stall));
        sb_push($sformatf("mem_req@%h", addr), 32'd0);
        #3;
        sb_pop(32'(hit));
        sb_pop(rd);
        sb_pop(32'(stall));
        sb_pop(32'(mem_req));
    endtask

    // Serves one line; pat[i] gives mem_rvalid for refill cycle i (1 past patlen)
    task automatic serve_refill(input logic [31:0] line, input logic [15:0] pat, input int patlen,
                                input int flush_beat, input int exp_stalls);
        int beats    = 0;
        int idx      = 0;
        int guard    = 0;
        int addr_bad = 0;
        int stalls   = 1;
        sb_push($sformatf("stall_cycles@%h", line), 32'(exp_stalls));
        sb_push($sformatf("beats@%h", line), 32'(c_BW));
        sb_push($sformatf("req_addr_unstable@%h", line), 32'd0);
        while (beats < c_BW && guard < 64) begin
            step();
            mem_rvalid = (idx < patlen) ? pat[idx[3:0]] : 1'b1;
            mem_rdata  = mem_rvalid ? bmem(line + 32'(beats * 4)) : 32'hDEAD_BEEF;
            flush      = mem_rvalid && (beats == flush_beat);
            idx++;
            guard++;
            #3;
            if (stall) stalls++;
            if (mem_req !== 1'b1 || mem_addr !== line) addr_bad++;
            if (mem_rvalid) beats++;
        end
        sb_pop(32'(stalls));
        sb_pop(32'(beats));
        sb_pop(32'(addr_bad));
    endtask

    task automatic flush_pulse();
        step();
        pc_valid   = 1'b0;
        flush      = 1'b1;
        mem_rvalid = 1'b0;
        sb_push("flush_req_stall", 32'd1);
        sb_push("flush_req_hit", 32'd0);
        #3;
        sb_pop(32'(stall));
        sb_pop(32'(hit));
        step();
        flush = 1'b0;
        sb_push("flush_cycle_stall", 32'd1);
        sb_push("flush_cycle_req", 32'd0);
        #3;
        sb_pop(32'(stall));
        sb_pop(32'(mem_req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        sb_push("rst_hit", 32'd0);
        sb_push("rst_stall", 32'd0);
        sb_push("rst_mem_req", 32'd0);
        sb_push("rst_rd", c_NOP);
        sb_pop(32'(hit));
        sb_pop(32'(stall));
        sb_pop(32'(mem_req));
        sb_pop(rd);
        step();
        RST_N = 1'b1;

        step();
        sb_push("idle_stall", 32'd0);
        sb_push("idle_rd", c_NOP);
        #3;
        sb_pop(32'(stall));
        sb_pop(rd);

        // Cold miss, back-to-back beats
        fetch(32'h100, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h100, 16'hFFFF, 0, -1, 5);
        for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(i * 4), 1'b1, 32'hA0 + 32'(i), 1'b0);

        // Flush in IDLE drops loaded lines
        flush_pulse();
        fetch(32'h108, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h100, 16'hFFFF, 0, -1, 5);
        fetch(32'h108, 1'b1, 32'hA2, 1'b0);

        // Fill set 0, touch way 0, then a miss evicts way 2 (0x080)
        flush_pulse();
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 64), 1'b0, c_NOP, 1'b1);
            serve_refill(32'(i * 64), 16'hFFFF, 0, -1, 5);
        end
        fetch(32'h000, 1'b1, bmem(32'h000), 1'b0);
        fetch(32'h100, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h100, 16'hFFFF, 0, -1, 5);
        fetch(32'h10C, 1'b1, 32'hA3, 1'b0);
        fetch(32'h044, 1'b1, bmem(32'h044), 1'b0);
        fetch(32'h0C8, 1'b1, bmem(32'h0C8), 1'b0);
        fetch(32'h080, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h080, 16'hFFFF, 0, -1, 5);

        // Gapped beats 1,0,0,1,1,0,1
        fetch(32'h214, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h210, 16'b1011001, 7, -1, 8);
        for (int i = 0; i < 4; i++) fetch(32'h210 + 32'(i * 4), 1'b1, bmem(32'h210 + 32'(i * 4)), 1'b0);

        // Flush on the 2nd beat: refill completes, FLUSH follows, line is gone
        fetch(32'h320, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h320, 16'hFFFF, 0, 1, 5);
        fetch(32'h320, 1'b0, c_NOP, 1'b1);
        fetch(32'h320, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h320, 16'hFFFF, 0, -1, 5);
        fetch(32'h324, 1'b1, bmem(32'h324), 1'b0);

        // Reset after two beats abandons the refill
        fetch(32'h430, 1'b0, c_NOP, 1'b1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = bmem(32'h430);
        step();
        mem_rdata  = bmem(32'h434);
        step();
        mem_rvalid = 1'b0;
        pc_valid   = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        sb_push("midrst_mem_req", 32'd0);
        sb_push("midrst_stall", 32'd0);
        sb_pop(32'(mem_req));
        sb_pop(32'(stall));
        step();
        step();
        RST_N = 1'b1;
        fetch(32'h430, 1'b0, c_NOP, 1'b1);
        serve_refill(32'h430, 16'hFFFF, 0, -1, 5);
        for (int i = 0; i < 4; i++) fetch(32'h430 + 32'(i * 4), 1'b1, bmem(32'h430 + 32'(i * 4)), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
